// File: rtl/riscv_pkg.sv
// Shared core constants and types for the register-file writeback path.
// RF_SIZE spans every thread's 32 architectural registers.
package riscv_pkg;
    localparam int NUM_THREADS = 16;
    localparam int NUM_REGS    = 32;
    localparam int RF_SIZE     = NUM_THREADS * NUM_REGS;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2,
        WB_RSVD = 2'd3
    } wb_sel_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
endpackage

// File: rtl/rf_write_ctrl_if.sv
// Writeback bundle between the pipeline and the register-file write port.
// The master side is the pipeline, which drives the retiring instruction.
interface rf_write_ctrl_if #(parameter int DWIDTH = 32);
    import riscv_pkg::*;
    localparam int TW = $clog2(NUM_THREADS);

    logic [TW-1:0]     thread_index_writeback;
    logic              reg_write;
    logic [4:0]        rd_addr;
    wb_sel_t           wb_sel;
    logic [DWIDTH-1:0] alu_result;
    logic [DWIDTH-1:0] load_word;
    logic [DWIDTH-1:0] pc_plus4;
    logic [2:0]        load_funct3;
    logic [1:0]        load_offset;

    logic              wr_en;
    logic [TW-1:0]     thread_index;
    logic [4:0]        write_addr;
    logic [DWIDTH-1:0] write_data;
    logic              init_done;

    modport master (
        output thread_index_writeback, reg_write, rd_addr, wb_sel,
               alu_result, load_word, pc_plus4, load_funct3, load_offset,
        input  wr_en, thread_index, write_addr, write_data, init_done
    );

    modport slave (
        input  thread_index_writeback, reg_write, rd_addr, wb_sel,
               alu_result, load_word, pc_plus4, load_funct3, load_offset,
        output wr_en, thread_index, write_addr, write_data, init_done
    );
endinterface

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a loaded word and extends it to DWIDTH.
module load_extend
    import riscv_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] word,
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    output logic [DWIDTH-1:0] ext
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[8*offset +: 8];
        // Halfword loads are aligned, so only offset[1] picks the half.
        half_sel = word[16*offset[1] +: 16];
        case (funct3)
            LB:      ext = {{(DWIDTH-8){byte_sel[7]}}, byte_sel};
            LBU:     ext = {{(DWIDTH-8){1'b0}}, byte_sel};
            LH:      ext = {{(DWIDTH-16){half_sel[15]}}, half_sel};
            LHU:     ext = {{(DWIDTH-16){1'b0}}, half_sel};
            default: ext = word;
        endcase
    end
endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write port controller: zero-fills the whole file after reset,
// then forwards registered writeback results, suppressing writes to x0.
module rf_write_ctrl
    import riscv_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [$clog2(NUM_THREADS)-1:0] i_thread_index_writeback,
    input  logic                           i_reg_write,
    input  logic [4:0]                     i_rd_addr,
    input  wb_sel_t                        i_wb_sel,
    input  logic [DWIDTH-1:0]              i_alu_result,
    input  logic [DWIDTH-1:0]              i_load_word,
    input  logic [DWIDTH-1:0]              i_pc_plus4,
    input  logic [2:0]                     i_load_funct3,
    input  logic [1:0]                     i_load_offset,
    output logic                           o_wr_en,
    output logic [$clog2(NUM_THREADS)-1:0] o_thread_index,
    output logic [4:0]                     o_write_addr,
    output logic [DWIDTH-1:0]              o_write_data,
    output logic                           o_init_done
);
    localparam int TW = $clog2(NUM_THREADS);
    localparam int CW = $clog2(RF_SIZE);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [TW-1:0]     thread_q, thread_d;
    logic [4:0]        addr_q, addr_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              init_done_q, init_done_d;
    logic [DWIDTH-1:0] load_ext;
    logic              sel_valid;

    load_extend #(.DWIDTH(DWIDTH)) u_load_extend (
        .word   (i_load_word),
        .funct3 (i_load_funct3),
        .offset (i_load_offset),
        .ext    (load_ext)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        // Lags the state by one cycle so done rises after the last sweep write.
        init_done_d = (state_q == ST_RUN);
        sel_valid   = 1'b1;
        wr_en_d     = 1'b0;
        thread_d    = i_thread_index_writeback;
        addr_d      = i_rd_addr;
        data_d      = '0;

        if (state_q == ST_INIT) begin
            wr_en_d  = 1'b1;
            thread_d = cnt_q[CW-1:5];
            addr_d   = cnt_q[4:0];
            data_d   = '0;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(RF_SIZE - 1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end else begin
            case (i_wb_sel)
                WB_ALU:  data_d = i_alu_result;
                WB_LOAD: data_d = load_ext;
                WB_PC4:  data_d = i_pc_plus4;
                default: begin
                    data_d    = '0;
                    sel_valid = 1'b0;
                end
            endcase
            wr_en_d = i_reg_write && (i_rd_addr != 5'd0) && sel_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            thread_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            thread_q    <= thread_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
        end
    end

    assign o_wr_en        = wr_en_q;
    assign o_thread_index = thread_q;
    assign o_write_addr   = addr_q;
    assign o_write_data   = data_q;
    assign o_init_done    = init_done_q;
endmodule

// File: tb/tb_rf_write_ctrl.sv
// Directed plus randomized bench for rf_write_ctrl against an arithmetic
// model of the writeback rules and the zero-fill sweep.
module tb_rf_write_ctrl;
    import riscv_pkg::*;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rf_write_ctrl_if #(.DWIDTH(DW)) bus ();

    rf_write_ctrl #(.DWIDTH(DW)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .i_thread_index_writeback (bus.thread_index_writeback),
        .i_reg_write              (bus.reg_write),
        .i_rd_addr                (bus.rd_addr),
        .i_wb_sel                 (bus.wb_sel),
        .i_alu_result             (bus.alu_result),
        .i_load_word              (bus.load_word),
        .i_pc_plus4               (bus.pc_plus4),
        .i_load_funct3            (bus.load_funct3),
        .i_load_offset            (bus.load_offset),
        .o_wr_en                  (bus.wr_en),
        .o_thread_index           (bus.thread_index),
        .o_write_addr             (bus.write_addr),
        .o_write_data             (bus.write_data),
        .o_init_done              (bus.init_done)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] pending;

    function automatic logic [63:0] pack(input bit done, input bit we, input int t,
                                         input int a, input logic [31:0] d);
        return {21'd0, done, we, t[3:0], a[4:0], d};
    endfunction

    function automatic logic [63:0] observed();
        return {21'd0, bus.init_done, bus.wr_en, bus.thread_index, bus.write_addr, bus.write_data};
    endfunction

    // Expected write in RUN, derived from the writeback rules with plain arithmetic.
    function automatic logic [63:0] ref_write(input int t, input bit rw, input int rd, input int sel,
                                              input logic [31:0] alu, input logic [31:0] lw,
                                              input logic [31:0] pc4, input int f3, input int off);
        logic [31:0] d;
        logic [31:0] v;
        bit we;
        we = rw && (rd != 0) && (sel != 3);
        case (sel)
            0: d = alu;
            2: d = pc4;
            1: begin
                case (f3)
                    0, 4: begin
                        v = (lw >> (8 * off)) & 32'hFF;
                        d = (f3 == 0 && v >= 128) ? v + 32'hFFFFFF00 : v;
                    end
                    1, 5: begin
                        v = (lw >> (16 * (off / 2))) & 32'hFFFF;
                        d = (f3 == 1 && v >= 32768) ? v + 32'hFFFF0000 : v;
                    end
                    default: d = lw;
                endcase
            end
            default: d = 32'd0;
        endcase
        return pack(1'b1, we, t, rd, d);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int t, input bit rw, input int rd, input int sel,
                         input logic [31:0] alu, input logic [31:0] lw, input logic [31:0] pc4,
                         input int f3, input int off);
        bus.thread_index_writeback = t[3:0];
        bus.reg_write              = rw;
        bus.rd_addr                = rd[4:0];
        bus.wb_sel                 = wb_sel_t'(sel[1:0]);
        bus.alu_result             = alu;
        bus.load_word              = lw;
        bus.pc_plus4               = pc4;
        bus.load_funct3            = f3[2:0];
        bus.load_offset            = off[1:0];
        pending = ref_write(t, rw, rd, sel, alu, lw, pc4, f3, off);
    endtask

    task automatic rand_drive();
        drive($urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 31),
              $urandom_range(0, 3), $urandom, $urandom, $urandom,
              $urandom_range(0, 7), $urandom_range(0, 3));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full zero-fill sweep with random pipeline traffic that must be ignored.
    task automatic sweep_check(input string tag);
        for (int i = 0; i < RF_SIZE; i++) begin
            rand_drive();
            tick();
            check(tag, observed(), pack(1'b0, 1'b1, i / 32, i % 32, 32'd0));
        end
        rand_drive();
        tick();
        check({tag, "_done"}, observed(), pending);
    endtask

    initial begin
        drive(0, 1'b0, 0, 0, '0, '0, '0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_state", observed(), 64'd0);
        reset = 1'b0;

        sweep_check("sweep");

        drive(3, 1'b1, 5, 0, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0);
        tick();
        check("alu_write", observed(), pack(1'b1, 1'b1, 3, 5, 32'hDEADBEEF));

        drive(1, 1'b1, 7, 1, 32'h0, 32'h80FF7F01, 32'h0, 0, 3);
        tick();
        check("lb_off3", observed(), pack(1'b1, 1'b1, 1, 7, 32'hFFFFFF80));
        drive(2, 1'b1, 8, 1, 32'h0, 32'h80FF7F01, 32'h0, 4, 3);
        tick();
        check("lbu_off3", observed(), pack(1'b1, 1'b1, 2, 8, 32'h00000080));
        drive(4, 1'b1, 9, 1, 32'h0, 32'h80FF7F01, 32'h0, 1, 2);
        tick();
        check("lh_off2", observed(), pack(1'b1, 1'b1, 4, 9, 32'hFFFF80FF));
        drive(5, 1'b1, 10, 1, 32'h0, 32'h80FF7F01, 32'h0, 5, 0);
        tick();
        check("lhu_off0", observed(), pack(1'b1, 1'b1, 5, 10, 32'h00007F01));
        drive(6, 1'b1, 11, 1, 32'h0, 32'h80FF7F01, 32'h0, 0, 1);
        tick();
        check("lb_off1", observed(), pack(1'b1, 1'b1, 6, 11, 32'h0000007F));
        drive(7, 1'b1, 12, 1, 32'h0, 32'h80FF7F01, 32'h0, 7, 1);
        tick();
        check("undef_f3_lw", observed(), pack(1'b1, 1'b1, 7, 12, 32'h80FF7F01));

        drive(9, 1'b1, 0, 2, 32'h0, 32'h0, 32'h104, 0, 0);
        tick();
        check("x0_suppress", observed(), pack(1'b1, 1'b0, 9, 0, 32'h104));
        drive(10, 1'b1, 13, 3, 32'h1234, 32'h5678, 32'h9ABC, 0, 0);
        tick();
        check("rsvd_sel", observed(), pack(1'b1, 1'b0, 10, 13, 32'h0));
        drive(11, 1'b1, 14, 2, 32'h0, 32'h0, 32'h00000200, 0, 0);
        tick();
        check("pc4_write", observed(), pack(1'b1, 1'b1, 11, 14, 32'h00000200));

        for (int t = 0; t < 16; t++) begin
            drive(t, 1'b1, t + 1, 0, 32'(t * 32'h11), $urandom, $urandom, 0, 0);
            tick();
            check("b2b", observed(), pack(1'b1, 1'b1, t, t + 1, 32'(t * 32'h11)));
        end

        for (int n = 0; n < 300; n++) begin
            rand_drive();
            tick();
            check("random", observed(), pending);
        end

        reset = 1'b1;
        tick();
        check("reset_in_run", observed(), 64'd0);
        reset = 1'b0;
        for (int i = 0; i <= 200; i++) begin
            rand_drive();
            tick();
            check("partial_sweep", observed(), pack(1'b0, 1'b1, i / 32, i % 32, 32'd0));
        end
        reset = 1'b1;
        tick();
        check("reset_mid_sweep", observed(), 64'd0);
        reset = 1'b0;
        sweep_check("resweep");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
